shift_normalizer: RTL and testbench

- Sequential inverse of the combinational logical barrel shifter: takes an 8-bit word, shifts it one bit per clock until its leading 1 reaches the target end, then reports the normalised word and the shift amount.
- `cntrl` selects direction, with the same convention as the shifter: 0 = left (MSB end), 1 = right (LSB end).
- For any word with its leading 1 at the target end, feeding `z` and `amt` back into the barrel shifter with the opposite `cntrl` reproduces the original `x`.
- Used for leading-zero/trailing-zero count and for recovering the shift amount applied by the shifter.

---
 rtl/shift_normalizer.sv | 138 +++++++++++++
 tb/tb_shift_normalizer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_normalizer
//  Description : Sequential normaliser. Shifts a captured word one bit per
//                clock until its leading 1 sits at the selected end, then
//                reports the normalised word and the number of shifts. It is
//                the inverse of the logical barrel shifter: feeding z and amt
//                back with the opposite direction reproduces x.
//                cntrl = 0 : normalise toward bit WIDTH-1 (shift left)
//                cntrl = 1 : normalise toward bit 0       (shift right)
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_normalizer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3   // must equal $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic             cntrl,
    output logic [WIDTH-1:0] z,
    output logic [AMT_W-1:0] amt,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q,  work_d;    // word being shifted
    logic             dir_q,   dir_d;     // captured direction
    logic [WIDTH-1:0] z_q,     z_d;
    logic [AMT_W-1:0] amt_q,   amt_d;
    logic             zero_q,  zero_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic             w_target_hit;       // leading 1 has reached the target end
    logic [WIDTH-1:0] w_work_shifted;     // working word moved one place

    // Target-bit test and single-step shift, both in the captured direction
    always_comb begin
        w_target_hit   = dir_q ? work_q[0] : work_q[WIDTH-1];
        w_work_shifted = dir_q ? (work_q >> 1) : (work_q << 1);
    end

    // Next-state and output-register logic
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        dir_d   = dir_q;
        z_d     = z_q;
        amt_d   = amt_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                busy_d = 1'b0;
                if (start) begin
                    work_d = x;
                    dir_d  = cntrl;
                    amt_d  = '0;
                    zero_d = 1'b0;
                    if (x == '0) begin
                        // Nothing to normalise: finish immediately
                        state_d = ST_DONE;
                        z_d     = '0;
                        zero_d  = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (w_target_hit) begin
                    // z only changes here so it holds the old result while shifting
                    z_d     = work_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    // A non-zero word hits the target within WIDTH-1 steps, so amt never wraps
                    work_d = w_work_shifted;
                    amt_d  = amt_q + AMT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            dir_q   <= 1'b0;
            z_q     <= '0;
            amt_q   <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            dir_q   <= dir_d;
            z_q     <= z_d;
            amt_q   <= amt_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign z    = z_q;
    assign amt  = amt_q;
    assign zero = zero_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_normalizer
//  Description : Scoreboard bench for shift_normalizer. The driver pushes the
//                expected result of every accepted request; a monitor pops and
//                compares on each done pulse and checks hold behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_normalizer;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    typedef struct {
        logic [7:0] x;
        logic       c;
        logic [7:0] z;
        logic [2:0] amt;
        logic       zero;
        int         lat;   // edges after the accepting edge until done is seen
        int         c0;
    } exp_t;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] x     = '0;
    logic             cntrl = 1'b0;
    logic [WIDTH-1:0] z;
    logic [AMT_W-1:0] amt;
    logic             zero;
    logic             busy;
    logic             done;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q[$];

    logic [7:0] last_z    = '0;
    logic [2:0] last_amt  = '0;
    logic       last_zero = 1'b0;
    exp_t       mon_e;

    shift_normalizer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .cntrl (cntrl),
        .z     (z),
        .amt   (amt),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: locate the leading 1 toward the target end and move it there
    function automatic exp_t model(input logic [7:0] xv, input logic cv);
        exp_t e;
        int   p;
        e.x = xv; e.c = cv; e.c0 = 0;
        e.z = '0; e.amt = '0; e.zero = (xv == 8'h00); e.lat = 0;
        p = 0;
        if (xv != 8'h00) begin
            if (!cv) begin
                for (int i = 0; i < 8; i++) if (xv[i]) p = i;
                e.amt = 3'(7 - p);
                e.z   = xv << (7 - p);
            end else begin
                for (int i = 7; i >= 0; i--) if (xv[i]) p = i;
                e.amt = 3'(p);
                e.z   = xv >> p;
            end
            e.lat = p_lat(e.amt);
        end
        return e;
    endfunction

    function automatic int p_lat(input logic [2:0] a);
        return int'(a) + 1;
    endfunction

    // Issue one request; b2b issues it in the done cycle, poke re-asserts start while busy
    task automatic do_op(input logic [7:0] xv, input logic cv, input bit b2b, input bit poke);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (b2b ? (done === 1'b1) : (busy === 1'b0)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("wait_ready", 32'(ok), 32'd1);
        start = 1'b1; x = xv; cntrl = cv;
        @(posedge clk); #1;
        e    = model(xv, cv);
        e.c0 = cyc;
        q.push_back(e);
        chk("busy_after_start", 32'(busy), 32'(xv != 8'h00));
        @(negedge clk);
        if (poke && xv != 8'h00) begin
            x = (~xv) ^ 8'h5a; cntrl = ~cv;
            @(negedge clk);
        end
        start = 1'b0;
        x     = 8'($urandom);
        cntrl = 1'($urandom);
    endtask

    // Monitor: compare results on done, check holds and exclusivity otherwise
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            last_z = '0; last_amt = '0; last_zero = 1'b0;
        end else begin
            chk("busy_done_excl", 32'(busy & done), 32'd0);
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual z=%0h amt=%0d required no done", z, amt);
                end else begin
                    mon_e = q.pop_front();
                    chk("z", 32'(z), 32'(mon_e.z));
                    chk("amt", 32'(amt), 32'(mon_e.amt));
                    chk("zero", 32'(zero), 32'(mon_e.zero));
                    chk("latency", 32'(cyc - mon_e.c0), 32'(mon_e.lat));
                    if (!mon_e.zero)
                        chk("roundtrip", 32'(mon_e.c ? (z << amt) : (z >> amt)), 32'(mon_e.x));
                    last_z = mon_e.z; last_amt = mon_e.amt; last_zero = mon_e.zero;
                end
            end else if (busy) begin
                chk("z_hold_busy", 32'(z), 32'(last_z));
                chk("zero_low_busy", 32'(zero), 32'd0);
            end else begin
                chk("z_hold_idle", 32'(z), 32'(last_z));
                chk("amt_hold_idle", 32'(amt), 32'(last_amt));
                chk("zero_hold_idle", 32'(zero), 32'(last_zero));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rx;
        logic       rc;
        bit         rb, rp;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_amt", 32'(amt), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        // Directed cases
        do_op(8'b0010_1101, 1'b0, 1'b0, 1'b0);
        do_op(8'b1011_0100, 1'b1, 1'b0, 1'b0);
        do_op(8'h01, 1'b0, 1'b0, 1'b0);
        do_op(8'h80, 1'b0, 1'b0, 1'b0);
        do_op(8'h80, 1'b1, 1'b0, 1'b0);
        do_op(8'h00, 1'b0, 1'b0, 1'b0);

        // Start while busy is ignored
        do_op(8'h2d, 1'b0, 1'b0, 1'b1);
        do_op(8'h01, 1'b1, 1'b0, 1'b1);

        // Start in the done cycle
        do_op(8'h01, 1'b0, 1'b0, 1'b0);
        do_op(8'h05, 1'b1, 1'b1, 1'b0);
        do_op(8'h00, 1'b0, 1'b1, 1'b0);
        do_op(8'h81, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a shift
        do_op(8'h01, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_z", 32'(z), 32'd0);
        chk("midrst_amt", 32'(amt), 32'd0);
        chk("midrst_zero", 32'(zero), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        do_op(8'h2d, 1'b0, 1'b0, 1'b0);

        // Randomised traffic
        for (int n = 0; n < 80; n++) begin
            rx = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rx = 8'h00;
            rc = 1'($urandom);
            rb = ($urandom_range(0, 2) == 0);
            rp = ($urandom_range(0, 3) == 0);
            do_op(rx, rc, rb, rp);
        end

        // Drain outstanding results
        for (int i = 0; i < 30; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 32'(q.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
